// File: rtl/ysyx_040750_axi_rdslave_pkg.sv
// Shared AXI read-path definitions: burst/resp encodings, slave FSM states and
// beat-level helpers, reused by the cache controllers.
package ysyx_040750_axi_rdslave_pkg;

  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_DATA_W  = 64;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W  = 2;
  localparam int unsigned LAT_W       = 4;

  typedef enum logic [AXI_BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [AXI_RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_DATA = 2'd3
  } rd_state_e;

  // Accepted AR request; burst kept raw since 2'b11 has no legal encoding.
  typedef struct packed {
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } ar_req_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_RESP_W-1:0] resp;
    logic                  last;
  } r_beat_t;

  // Response of a single beat: unsupported burst/size beats the range check.
  function automatic axi_resp_e beat_resp(input logic [AXI_ADDR_W-1:0]  addr,
                                          input logic [AXI_SIZE_W-1:0]  size,
                                          input logic [AXI_BURST_W-1:0] burst,
                                          input logic [AXI_ADDR_W-1:0]  base,
                                          input logic [AXI_ADDR_W-1:0]  span);
    if (burst[1] || (size > 3'd3)) return RESP_SLVERR;
    if ((addr - base) >= span)     return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  // FIXED keeps the address; INCR steps by the transfer size and may wrap 2^32.
  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0]  addr,
                                                      input logic [AXI_SIZE_W-1:0]  size,
                                                      input logic [AXI_BURST_W-1:0] burst);
    if (burst == BURST_INCR) return addr + (AXI_ADDR_W'(1) << size);
    return addr;
  endfunction

endpackage

// File: rtl/ysyx_040750_axi_rdslave.sv
// AXI4 read-only slave in front of an external 64-bit SRAM: one SRAM read per
// beat, programmable start latency, per-beat DECERR/SLVERR reporting.
module ysyx_040750_axi_rdslave
  import ysyx_040750_axi_rdslave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                         I_clk,
  input  logic                         I_rst_n,
  input  logic [AXI_ADDR_W-1:0]        I_araddr,
  input  logic                         I_arvalid,
  output logic                         O_arready,
  input  logic [AXI_LEN_W-1:0]         I_arlen,
  input  logic [AXI_SIZE_W-1:0]        I_arsize,
  input  logic [AXI_BURST_W-1:0]       I_arburst,
  output logic [AXI_DATA_W-1:0]        O_rdata,
  output logic [AXI_RESP_W-1:0]        O_rresp,
  output logic                         O_rvalid,
  output logic                         O_rlast,
  input  logic                         I_rready,
  output logic [$clog2(MEM_DEPTH)-1:0] O_sram_addr,
  output logic                         O_sram_cen,
  input  logic [AXI_DATA_W-1:0]        I_sram_rdata
);

  localparam int unsigned            SRAM_AW  = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_W-1:0]  SPAN     = AXI_ADDR_W'(8 * MEM_DEPTH);
  localparam logic [LAT_W-1:0]       LAT_INIT = LAT_W'(LATENCY);

  rd_state_e              state_q, state_d;
  ar_req_t                req_q, req_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [AXI_LEN_W-1:0]   beat_q, beat_d;
  r_beat_t                r_q, r_d;
  logic                   rvalid_q, rvalid_d;
  logic                   arready_q, arready_d;
  logic                   sram_cen_q, sram_cen_d;
  logic [SRAM_AW-1:0]     sram_addr_q, sram_addr_d;
  axi_resp_e              cur_resp, nxt_resp;

  // Next-state, beat bookkeeping and SRAM request for the upcoming cycle.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    r_d         = r_q;
    rvalid_d    = rvalid_q;
    sram_addr_d = sram_addr_q;
    sram_cen_d  = 1'b1;
    cur_resp    = beat_resp(req_q.addr, req_q.size, req_q.burst, ADDR_BASE, SPAN);

    unique case (state_q)
      ST_IDLE: begin
        if (I_arvalid && arready_q) begin
          req_d   = '{addr: I_araddr, size: I_arsize, burst: I_arburst};
          lat_d   = LAT_INIT;
          beat_d  = I_arlen;
          state_d = (LATENCY != 0) ? ST_WAIT : ST_READ;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) state_d = ST_READ;
      end
      ST_READ: begin
        state_d  = ST_DATA;
        rvalid_d = 1'b1;
        r_d.data = (cur_resp == RESP_OKAY) ? I_sram_rdata : '0;
        r_d.resp = cur_resp;
        r_d.last = (beat_q == '0);
      end
      ST_DATA: begin
        if (I_rready) begin
          rvalid_d = 1'b0;
          r_d.last = 1'b0;
          if (beat_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            beat_d     = beat_q - AXI_LEN_W'(1);
            req_d.addr = next_addr(req_q.addr, req_q.size, req_q.burst);
            state_d    = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only a legal, in-range beat entering READ touches the SRAM.
    nxt_resp = beat_resp(req_d.addr, req_d.size, req_d.burst, ADDR_BASE, SPAN);
    if ((state_d == ST_READ) && (nxt_resp == RESP_OKAY)) begin
      sram_cen_d  = 1'b0;
      sram_addr_d = SRAM_AW'((req_d.addr - ADDR_BASE) >> 3);
    end
    arready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      lat_q       <= '0;
      beat_q      <= '0;
      r_q         <= '0;
      rvalid_q    <= 1'b0;
      arready_q   <= 1'b0;
      sram_cen_q  <= 1'b1;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      r_q         <= r_d;
      rvalid_q    <= rvalid_d;
      arready_q   <= arready_d;
      sram_cen_q  <= sram_cen_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  assign O_arready   = arready_q;
  assign O_rvalid    = rvalid_q;
  assign O_rdata     = r_q.data;
  assign O_rresp     = r_q.resp;
  assign O_rlast     = r_q.last;
  assign O_sram_cen  = sram_cen_q;
  assign O_sram_addr = sram_addr_q;

endmodule

// File: tb/tb_ysyx_040750_axi_rdslave.sv
// Bench for the AXI read slave: burst-level beat model plus directed bursts.
module tb_ysyx_040750_axi_rdslave;
  import ysyx_040750_axi_rdslave_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rlast, rready;
  logic [AW-1:0] sram_addr;
  logic        sram_cen;
  logic [63:0] sram_rdata;

  always #5 clk = ~clk;

  ysyx_040750_axi_rdslave #(.ADDR_BASE(BASE), .MEM_DEPTH(DEPTH), .LATENCY(2)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_araddr(araddr), .I_arvalid(arvalid), .O_arready(arready),
    .I_arlen(arlen), .I_arsize(arsize), .I_arburst(arburst),
    .O_rdata(rdata), .O_rresp(rresp), .O_rvalid(rvalid), .O_rlast(rlast),
    .I_rready(rready),
    .O_sram_addr(sram_addr), .O_sram_cen(sram_cen), .I_sram_rdata(sram_rdata)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] i);
    return {32'hC0DE_0000 + i, 32'h1234_5678 ^ i};
  endfunction

  // SRAM content while enabled; a poison pattern otherwise.
  assign sram_rdata = (sram_cen == 1'b0) ? mem_word(32'(sram_addr)) : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        ok;
    logic [31:0] idx;
  } exp_t;

  exp_t      exp_q[$];
  r_beat_t   obs_q[$];
  exp_t      e_cur;
  r_beat_t   prev;
  int        checks = 0;
  int        errors = 0;
  int        hs_cnt = 0;
  int        cen_low_cnt = 0;
  logic      read_seen = 1'b0;
  logic      stall_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected beats of one burst, straight from the address/size/burst rules.
  task automatic push_burst(input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
    logic [31:0] cur;
    logic [31:0] off;
    exp_t e;
    cur = a;
    for (int i = 0; i <= int'(l); i++) begin
      off = cur - BASE;
      if (b[1] || s > 3'd3)            e.resp = 2'b10;
      else if (off >= 32'(8 * DEPTH))  e.resp = 2'b11;
      else                             e.resp = 2'b00;
      e.ok   = (e.resp == 2'b00);
      e.idx  = off >> 3;
      e.data = e.ok ? mem_word(off >> 3) : 64'd0;
      e.last = (i == int'(l));
      exp_q.push_back(e);
      if (b == 2'b01) cur = cur + (32'd1 << s);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && rvalid && rready) hs_cnt++;
    if (rst_n && sram_cen === 1'b0) cen_low_cnt++;
  end

  // Compare process: SRAM reads, R beats and stall stability, every cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_rvalid_hold", 64'(rvalid), 64'd1);
        chk("stall_rdata_hold", rdata, prev.data);
        chk("stall_rresp_hold", 64'(rresp), 64'(prev.resp));
        chk("stall_rlast_hold", 64'(rlast), 64'(prev.last));
      end
      if (sram_cen === 1'b0) begin
        chk("sram_read_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("sram_read_legal", 64'(exp_q[0].ok), 64'd1);
          chk("sram_read_once", 64'(read_seen), 64'd0);
          chk("sram_addr", 64'(sram_addr), 64'(exp_q[0].idx));
        end
        read_seen = 1'b1;
      end
      if (rvalid && rready) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e_cur = exp_q.pop_front();
          chk("rdata", rdata, e_cur.data);
          chk("rresp", 64'(rresp), 64'(e_cur.resp));
          chk("rlast", 64'(rlast), 64'(e_cur.last));
          chk("beat_sram_read", 64'(read_seen), 64'(e_cur.ok));
        end
        obs_q.push_back('{data: rdata, resp: rresp, last: rlast});
        read_seen = 1'b0;
      end
      stall_prev = rvalid && !rready;
      prev       = '{data: rdata, resp: rresp, last: rlast};
    end else begin
      stall_prev = 1'b0;
      read_seen  = 1'b0;
    end
  end

  // Issue one AR request; returns cycles from handshake to first rvalid.
  task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] b, output int lat);
    int n;
    @(negedge clk);
    araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("arready_timeout", 64'(arready), 64'd1);
    push_burst(a, l, s, b);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("rvalid_timeout", 64'(rvalid), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rvalid || !arready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(exp_q.size() == 0 && !rvalid && arready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          c0;
    int          base;
    int          n;
    logic [1:0]  er [4];

    rst_n = 1'b0; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_sram_cen", 64'(sram_cen), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arready_after_rst", 64'(arready), 64'd1);
    rready = 1'b1;

    // INCR 4 x 64-bit from word 4
    obs_q.delete(); c0 = cen_low_cnt;
    issue(32'h8000_0020, 8'd3, 3'd3, 2'b01, lat);
    chk("first_rvalid_latency", 64'(lat), 64'd4);
    chk("first_rdata", rdata, 64'hC0DE_0004_1234_567C);
    wait_idle();
    chk("incr_beats", 64'(obs_q.size()), 64'd4);
    chk("incr_last_on_4th", 64'(obs_q[3].last), 64'd1);
    chk("incr_no_early_last", 64'(obs_q[2].last), 64'd0);
    chk("incr_word7", obs_q[3].data, 64'hC0DE_0007_1234_567F);
    chk("incr_sram_reads", 64'(cen_low_cnt - c0), 64'd4);

    // Out-of-range single beat
    obs_q.delete(); c0 = cen_low_cnt;
    issue(32'h1000_0000, 8'd0, 3'd2, 2'b00, lat);
    wait_idle();
    chk("decerr_resp", 64'(obs_q[0].resp), 64'd3);
    chk("decerr_rdata", obs_q[0].data, 64'd0);
    chk("decerr_rlast", 64'(obs_q[0].last), 64'd1);
    chk("decerr_no_sram", 64'(cen_low_cnt - c0), 64'd0);

    // Stall beat 2 for 5 cycles
    obs_q.delete(); base = hs_cnt;
    issue(32'h8000_0100, 8'd3, 3'd3, 2'b01, lat);
    n = 0;
    while (hs_cnt == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    @(negedge clk);
    c0 = cen_low_cnt;
    chk("stall_beat2_rdata", rdata, 64'hC0DE_0021_1234_5659);
    repeat (4) @(negedge clk);
    chk("stall_still_valid", 64'(rvalid), 64'd1);
    chk("stall_rdata_lit", rdata, 64'hC0DE_0021_1234_5659);
    chk("stall_no_sram", 64'(cen_low_cnt - c0), 64'd0);
    rready = 1'b1;
    wait_idle();
    chk("stall_beats", 64'(obs_q.size()), 64'd4);

    // Crossing the end of the SRAM window
    obs_q.delete();
    er = '{2'b00, 2'b00, 2'b11, 2'b11};
    issue(BASE + 32'(8 * DEPTH) - 32'd16, 8'd3, 3'd3, 2'b01, lat);
    wait_idle();
    for (int i = 0; i < 4; i++) chk($sformatf("cross_resp%0d", i), 64'(obs_q[i].resp), 64'(er[i]));
    chk("cross_word255", obs_q[1].data, 64'hC0DE_00FF_1234_5687);

    // Byte INCR then FIXED held on AR while the first burst runs
    obs_q.delete();
    issue(32'h8000_0006, 8'd3, 3'd0, 2'b01, lat);
    issue(32'h8000_0008, 8'd2, 3'd3, 2'b00, lat);
    wait_idle();
    chk("b2b_beats", 64'(obs_q.size()), 64'd7);
    chk("byte_word0", obs_q[1].data, 64'hC0DE_0000_1234_5678);
    chk("byte_word1", obs_q[2].data, 64'hC0DE_0001_1234_5679);
    for (int i = 4; i < 7; i++) chk($sformatf("fixed_word1_%0d", i), obs_q[i].data, 64'hC0DE_0001_1234_5679);

    // Oversized transfer
    obs_q.delete();
    issue(32'h8000_0000, 8'd0, 3'd4, 2'b01, lat);
    wait_idle();
    chk("size4_slverr", 64'(obs_q[0].resp), 64'd2);

    // WRAP burst unsupported
    obs_q.delete(); c0 = cen_low_cnt;
    issue(32'h8000_0000, 8'd1, 3'd3, 2'b10, lat);
    wait_idle();
    chk("wrap_beats", 64'(obs_q.size()), 64'd2);
    chk("wrap_resp0", 64'(obs_q[0].resp), 64'd2);
    chk("wrap_resp1", 64'(obs_q[1].resp), 64'd2);
    chk("wrap_no_sram", 64'(cen_low_cnt - c0), 64'd0);

    // Reset during beat 1
    rready = 1'b0;
    issue(32'h8000_0000, 8'd1, 3'd3, 2'b10, lat);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mid_arready", 64'(arready), 64'd0);
    chk("rst_mid_rresp", 64'(rresp), 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_arready_release", 64'(arready), 64'd1);
    rready = 1'b1;

    // Normal traffic after the abort
    obs_q.delete();
    issue(32'h8000_0010, 8'd0, 3'd3, 2'b01, lat);
    wait_idle();
    chk("post_rst_word2", obs_q[0].data, 64'hC0DE_0002_1234_567A);
    chk("post_rst_beats", 64'(obs_q.size()), 64'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_040750_axi_rdslave.md
YSYX_040750_AXI_RDSLAVE -- requirements
Module: ysyx_040750_axi_rdslave

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h8000_0000: first byte address served.
REQ-002 SHALL have parameter MEM_DEPTH, default 4096: number of 64-bit words in the backing SRAM.
REQ-003 SHALL have parameter LATENCY, default 2: idle cycles inserted between AR handshake and first SRAM read; range 0..15.
REQ-004 SHALL have ports: I_clk in 1 clock; I_rst_n in 1 reset, one clock, synchronous, active-low.
REQ-005 SHALL have AR channel: I_araddr in 32; I_arvalid in 1; O_arready out 1; I_arlen in 8; I_arsize in 3; I_arburst in 2.
REQ-006 SHALL have R channel: O_rdata out 64; O_rresp out 2; O_rvalid out 1; O_rlast out 1; I_rready in 1.
REQ-007 SHALL have SRAM port: O_sram_addr out $clog2(MEM_DEPTH), word index; O_sram_cen out 1, low-active read enable; I_sram_rdata in 64, valid the cycle after cen low.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, READ, DATA.
REQ-009 SHALL drive O_arready=1 only in IDLE while I_rst_n=1; AR handshake = I_arvalid & O_arready.
REQ-010 SHALL, on AR handshake, latch addr, len, size, burst, load latency counter with LATENCY, load beat counter with I_arlen; go to WAIT if LATENCY>0, else READ.
REQ-011 SHALL decrement latency counter each WAIT cycle and enter READ the cycle it reaches 1.
REQ-012 SHALL, in READ, assert O_sram_cen=0 with O_sram_addr=(addr-ADDR_BASE)>>3 for legal in-range beats; then enter DATA.
REQ-013 SHALL, on entering DATA, register I_sram_rdata into O_rdata and hold O_rvalid=1 with O_rdata, O_rresp, O_rlast stable until I_rready=1.
REQ-014 SHALL, on R handshake: if beat counter=0, go to IDLE; else decrement beat counter, advance addr, go to READ. With I_rready held high, beats occur every 2 cycles.
REQ-015 SHALL advance addr by (1<<size) for INCR (2'b01) and keep addr unchanged for FIXED (2'b00); 32-bit wrap-around of addr SHALL NOT be prevented.
REQ-016 SHALL return the full 64-bit word containing addr for size 0..3; master selects the lane.
REQ-017 SHALL drive O_rlast=1 exactly on the beat where beat counter=0.
REQ-018 SHALL respond O_rresp=2'b11 (DECERR), O_rdata=0, no SRAM access, for any beat whose addr is outside [ADDR_BASE, ADDR_BASE+8*MEM_DEPTH).
REQ-019 SHALL respond O_rresp=2'b10 (SLVERR), O_rdata=0, no SRAM access, for every beat of a burst with arburst=2'b10/2'b11 or arsize>3; burst length still honoured.
REQ-020 SHALL otherwise respond O_rresp=2'b00; error is evaluated per beat, so an INCR burst crossing the range end returns OKAY then DECERR.
REQ-021 SHALL keep O_sram_cen=1 in every state except READ.
REQ-022 SHALL ignore I_arvalid outside IDLE; a request held during a burst is accepted in the first IDLE cycle.

Reset
REQ-023 SHALL, while I_rst_n=0 at a clock edge, force state IDLE and counters 0, and hold O_arready=0, O_rvalid=0, O_rlast=0, O_rresp=0, O_rdata=0, O_sram_cen=1.
REQ-024 SHALL abort any in-flight burst on reset without completing remaining beats; O_arready=1 the first cycle after I_rst_n returns to 1.

Structure
REQ-025 SHALL place burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR/DECERR) and FSM state encodings in the shared ysyx_040750 AXI defines package, reused by the icache/dcache controllers.
REQ-026 SHALL be a single module; SRAM is external, no sub-module.

Verification
REQ-027 SHALL cover: AR addr 0x8000_0020, len 3, size 3, INCR, rready=1 -> 4 OKAY beats, words 4,5,6,7, rlast on 4th, first rvalid LATENCY+2 cycles after handshake.
REQ-028 SHALL cover: addr 0x1000_0000, len 0, size 2, FIXED -> 1 beat rresp=2'b11, rdata=0, rlast=1, O_sram_cen never low.
REQ-029 SHALL cover: INCR len 3 with rready low 5 cycles on beat 2 -> rdata/rresp/rlast stable, no SRAM read issued while stalled.
REQ-030 SHALL cover: addr ADDR_BASE+8*MEM_DEPTH-16, len 3, INCR -> OKAY, OKAY, DECERR, DECERR.
REQ-031 SHALL cover: arburst=2'b10, len 1 -> 2 SLVERR beats; and reset asserted during beat 1 -> rvalid=0 next cycle, arready=1 the cycle after reset release.
REQ-032 SHALL cover: FIXED len 2 at 0x8000_0008 -> three beats all returning word 1.
